cpu_ctrl_fsm: RTL and testbench
===============================

Name: cpu_ctrl_fsm

Overview:
Multicycle CPU control unit with an internal state register. It replaces the earlier controller, whose state and next-state were held externally. It decodes the instruction register, sequences fetch/execute micro-steps and drives the datapath load (L*) and transfer (T*) strobes. Memory accesses use a ready handshake with wait states. Instruction width, state width and wait counter width are parametrised.

Parameters:
IR_W, 16, instruction register width; opcode = IR[IR_W-1 -: 4], condition = IR[IR_W-5 -: 3]
STATE_W, 4, state register width (>=4)
CNT_W, 3, wait-cycle counter width
TIMEOUT, 7, wait-cycle limit used only with CTRL_MEM_TIMEOUT_EN (must be < 2^CNT_W)

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  synchronous reset, active-low
IR  in  IR_W  current instruction
C, V, S, Z  in  1 each  ALU flags (carry, overflow, sign, zero)
mem_ready  in  1  memory completes current rd/wr this cycle
Lmar, Lir, Lbuff, Lpc, Lsp, Lreg, Lmdr  out  1  register load strobes
Tpc, Tmar, Tmdr, T1, Tbuff, Tsp, Treg, Tlabel, Tir  out  1  bus drive strobes
rd, wr  out  1  memory read/write request
pc_inc  out  1  with Lpc: load PC+1
fsel  out  3  ALU function select
count  out  CNT_W  cycles spent waiting in current memory state
state_o  out  STATE_W  current state
halted  out  1  in HALT
illegal  out  1  one-cycle pulse on undefined opcode
fault  out  1  in FAULT (timeout build only, else tied 0)

Behaviour:
- Moore outputs, combinational decode of the registered state. Any strobe not listed for a state is 0. fsel is 0 except in ALU_WB.
- Reset (rst=0 at edge): state=IDLE(0), count=0. In IDLE all outputs are 0. rst has priority over every transition.
- States and encodings:
  - IDLE(0): no strobes -> F_ADDR.
  - F_ADDR(1): Tpc, Lmar -> F_READ.
  - F_READ(2): rd=1. mem_ready=1 -> Lmdr=1, go F_IR. Otherwise stay.
  - F_IR(3): Tmdr, Lir, Lpc, pc_inc -> DECODE.
  - DECODE(4): no strobes. Dispatch on opcode:
    - 0x0-0x7 -> ALU_OP
    - 0x8 LOAD or 0x9 STORE -> M_ADDR
    - 0xA JMP -> BRANCH
    - 0xF -> HALT
    - 0xB-0xE -> illegal=1 this cycle, go F_ADDR
  - ALU_OP(5): Treg, Lbuff -> ALU_WB.
  - ALU_WB(6): Tbuff, Lreg, fsel=opcode[2:0] -> F_ADDR.
  - M_ADDR(7): Tlabel, Lmar. LOAD -> M_READ, STORE -> M_DATA.
  - M_READ(8): rd=1. mem_ready -> Lmdr, go M_WB.
  - M_WB(9): Tmdr, Lreg -> F_ADDR.
  - M_DATA(10): Treg, Lmdr -> M_WRITE.
  - M_WRITE(11): wr=1, held until mem_ready -> F_ADDR.
  - BRANCH(12): if the condition holds, Tlabel, Lpc (pc_inc=0). Always -> F_ADDR.
  - HALT(13): halted=1, no strobes, stays until reset.
  - FAULT(14): fault=1, no strobes, stays until reset.
- Branch conditions (flags sampled in the BRANCH cycle): 000 always, 001 Z, 010 !Z, 011 C, 100 S, 101 V, 110/111 never.
- Memory states are F_READ, M_READ and M_WRITE:
  - rd/wr stay asserted continuously until the mem_ready cycle and drop on the following cycle.
  - mem_ready outside memory states is ignored.
  - rd and wr are never both 1.
- count is 0 on entry to any state. It increments each memory-state cycle with mem_ready=0 and saturates at 2^CNT_W-1. It is 0 in non-memory states.
- IR must be stable from F_IR through the end of the instruction. The block does not latch it.

Optional Feature:
CTRL_MEM_TIMEOUT_EN
- Defined: in a memory state, when count==TIMEOUT and mem_ready=0, the next state is FAULT and rd/wr drop. mem_ready=1 in that same cycle wins (normal completion).
- Undefined: waits indefinitely, FAULT is unreachable and fault is tied 0.

Test Plan:
- Reset: rst=0 for 2 cycles mid-M_WRITE -> state_o=0, wr=0, all strobes 0. Release rst -> state_o=1 next cycle with Tpc=Lmar=1.
- ALU with wait states: IR=0x2000, mem_ready low 3 cycles in F_READ -> rd=1 for 4 cycles, count 0,1,2,3, Lmdr only in the ready cycle. Then ALU_OP (Treg, Lbuff) and ALU_WB with fsel=3'b010, Lreg=1. Back to state 1; instruction total 9 cycles.
- Branch on Z: IR=0xA200 with Z=0 -> BRANCH asserts no Lpc. With Z=1 -> Tlabel=Lpc=1, pc_inc=0.
- Store: IR=0x9005, mem_ready arrives after 2 wait cycles -> M_DATA shows Treg=Lmdr=1, wr=1 for 3 cycles, then state 1.
- Halt and illegal: IR=0xF400 -> halted=1 and state_o=13 for 100 cycles with mem_ready toggling. IR=0xC000 -> illegal pulse exactly 1 cycle, then F_ADDR.
- Timeout: mem_ready held 0 in F_READ. With CTRL_MEM_TIMEOUT_EN, TIMEOUT=7 -> FAULT (state 14, fault=1) after 8 wait cycles. Without the macro -> remains in state 2 with count stuck at 7.

Source files
------------

// File: rtl/cpu_ctrl_fsm.sv
// Multicycle CPU control unit: internal state register, Moore strobe decode, memory wait handshake.
// Optional build macro CTRL_MEM_TIMEOUT_EN bounds memory waits and traps to FAULT.
module cpu_ctrl_fsm #(
  parameter int IR_W    = 16,
  parameter int STATE_W = 4,
  parameter int CNT_W   = 3,
  parameter int TIMEOUT = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IR_W-1:0]    IR,
  input  logic               C,
  input  logic               V,
  input  logic               S,
  input  logic               Z,
  input  logic               mem_ready,
  output logic               Lmar,
  output logic               Lir,
  output logic               Lbuff,
  output logic               Lpc,
  output logic               Lsp,
  output logic               Lreg,
  output logic               Lmdr,
  output logic               Tpc,
  output logic               Tmar,
  output logic               Tmdr,
  output logic               T1,
  output logic               Tbuff,
  output logic               Tsp,
  output logic               Treg,
  output logic               Tlabel,
  output logic               Tir,
  output logic               rd,
  output logic               wr,
  output logic               pc_inc,
  output logic [2:0]         fsel,
  output logic [CNT_W-1:0]   count,
  output logic [STATE_W-1:0] state_o,
  output logic               halted,
  output logic               illegal,
  output logic               fault
);

  typedef enum logic [STATE_W-1:0] {
    IDLE    = STATE_W'(0),
    F_ADDR  = STATE_W'(1),
    F_READ  = STATE_W'(2),
    F_IR    = STATE_W'(3),
    DECODE  = STATE_W'(4),
    ALU_OP  = STATE_W'(5),
    ALU_WB  = STATE_W'(6),
    M_ADDR  = STATE_W'(7),
    M_READ  = STATE_W'(8),
    M_WB    = STATE_W'(9),
    M_DATA  = STATE_W'(10),
    M_WRITE = STATE_W'(11),
    BRANCH  = STATE_W'(12),
    HALT    = STATE_W'(13),
    FAULT   = STATE_W'(14)
  } state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] count_nx;
  logic [3:0]       opcode;
  logic [2:0]       cond;
  logic             mem_st;
  logic             cond_ok;
  logic             timeout_hit;
  logic             unused_ir;
  logic             unused_cfg;

  assign opcode     = IR[IR_W-1 -: 4];
  assign cond       = IR[IR_W-5 -: 3];
  assign mem_st     = (state == F_READ) || (state == M_READ) || (state == M_WRITE);
  assign unused_ir  = ^IR[IR_W-8:0];
  assign unused_cfg = (count == CNT_W'(TIMEOUT));

`ifdef CTRL_MEM_TIMEOUT_EN
  assign timeout_hit = mem_st && !mem_ready && (count == CNT_W'(TIMEOUT));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      3'b000:  cond_ok = 1'b1;
      3'b001:  cond_ok = Z;
      3'b010:  cond_ok = !Z;
      3'b011:  cond_ok = C;
      3'b100:  cond_ok = S;
      3'b101:  cond_ok = V;
      default: cond_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= next_state;
      count <= count_nx;
    end
  end

  always_comb begin
    next_state = state;
    if (timeout_hit) begin
      next_state = FAULT;
    end else begin
      case (state)
        IDLE:    next_state = F_ADDR;
        F_ADDR:  next_state = F_READ;
        F_READ:  if (mem_ready) next_state = F_IR;
        F_IR:    next_state = DECODE;
        DECODE: begin
          if (opcode[3] == 1'b0)  next_state = ALU_OP;
          else if (opcode == 4'h8 || opcode == 4'h9) next_state = M_ADDR;
          else if (opcode == 4'hA) next_state = BRANCH;
          else if (opcode == 4'hF) next_state = HALT;
          else                     next_state = F_ADDR;
        end
        ALU_OP:  next_state = ALU_WB;
        ALU_WB:  next_state = F_ADDR;
        M_ADDR:  next_state = (opcode == 4'h9) ? M_DATA : M_READ;
        M_READ:  if (mem_ready) next_state = M_WB;
        M_WB:    next_state = F_ADDR;
        M_DATA:  next_state = M_WRITE;
        M_WRITE: if (mem_ready) next_state = F_ADDR;
        BRANCH:  next_state = F_ADDR;
        HALT:    next_state = HALT;
        FAULT:   next_state = FAULT;
        default: next_state = IDLE;
      endcase
    end
  end

  // Counter clears whenever the state changes, so it reads 0 on entry to every state.
  always_comb begin
    count_nx = count;
    if (next_state != state)
      count_nx = '0;
    else if (mem_st && !mem_ready && count != '1)
      count_nx = count + 1'b1;
  end

  always_comb begin
    Lmar = 1'b0; Lir = 1'b0; Lbuff = 1'b0; Lpc = 1'b0; Lsp = 1'b0; Lreg = 1'b0; Lmdr = 1'b0;
    Tpc = 1'b0; Tmar = 1'b0; Tmdr = 1'b0; T1 = 1'b0; Tbuff = 1'b0; Tsp = 1'b0;
    Treg = 1'b0; Tlabel = 1'b0; Tir = 1'b0;
    rd = 1'b0; wr = 1'b0; pc_inc = 1'b0; fsel = '0;
    halted = 1'b0; illegal = 1'b0; fault = 1'b0;
    state_o = state;
    case (state)
      F_ADDR:  begin Tpc = 1'b1; Lmar = 1'b1; end
      F_READ:  begin rd = 1'b1; Lmdr = mem_ready; end
      F_IR:    begin Tmdr = 1'b1; Lir = 1'b1; Lpc = 1'b1; pc_inc = 1'b1; end
      DECODE:  illegal = (opcode >= 4'hB) && (opcode <= 4'hE);
      ALU_OP:  begin Treg = 1'b1; Lbuff = 1'b1; end
      ALU_WB:  begin Tbuff = 1'b1; Lreg = 1'b1; fsel = opcode[2:0]; end
      M_ADDR:  begin Tlabel = 1'b1; Lmar = 1'b1; end
      M_READ:  begin rd = 1'b1; Lmdr = mem_ready; end
      M_WB:    begin Tmdr = 1'b1; Lreg = 1'b1; end
      M_DATA:  begin Treg = 1'b1; Lmdr = 1'b1; end
      M_WRITE: wr = 1'b1;
      BRANCH:  begin Tlabel = cond_ok; Lpc = cond_ok; end
      HALT:    halted = 1'b1;
`ifdef CTRL_MEM_TIMEOUT_EN
      FAULT:   fault = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm: instruction-level plans expand into expected per-cycle outputs.
// Honours CTRL_MEM_TIMEOUT_EN when the design is built with it.
module tb_cpu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] IR;
  logic        C, V, S, Z, mem_ready;
  logic        Lmar, Lir, Lbuff, Lpc, Lsp, Lreg, Lmdr;
  logic        Tpc, Tmar, Tmdr, T1, Tbuff, Tsp, Treg, Tlabel, Tir;
  logic        rd, wr, pc_inc, halted, illegal, fault;
  logic [2:0]  fsel;
  logic [2:0]  count;
  logic [3:0]  state_o;

  cpu_ctrl_fsm #(.IR_W(16), .STATE_W(4), .CNT_W(3), .TIMEOUT(7)) dut (
    .clk(clk), .rst(rst), .IR(IR), .C(C), .V(V), .S(S), .Z(Z), .mem_ready(mem_ready),
    .Lmar(Lmar), .Lir(Lir), .Lbuff(Lbuff), .Lpc(Lpc), .Lsp(Lsp), .Lreg(Lreg), .Lmdr(Lmdr),
    .Tpc(Tpc), .Tmar(Tmar), .Tmdr(Tmdr), .T1(T1), .Tbuff(Tbuff), .Tsp(Tsp), .Treg(Treg),
    .Tlabel(Tlabel), .Tir(Tir), .rd(rd), .wr(wr), .pc_inc(pc_inc), .fsel(fsel),
    .count(count), .state_o(state_o), .halted(halted), .illegal(illegal), .fault(fault)
  );

  always #5 clk = ~clk;

  localparam logic [21:0] M_LMAR = 22'(1) << 21, M_LIR = 22'(1) << 20, M_LBUFF = 22'(1) << 19;
  localparam logic [21:0] M_LPC = 22'(1) << 18, M_LREG = 22'(1) << 16, M_LMDR = 22'(1) << 15;
  localparam logic [21:0] M_TPC = 22'(1) << 14, M_TMDR = 22'(1) << 12, M_TBUFF = 22'(1) << 10;
  localparam logic [21:0] M_TREG = 22'(1) << 8, M_TLABEL = 22'(1) << 7;
  localparam logic [21:0] M_RD = 22'(1) << 5, M_WR = 22'(1) << 4, M_PCINC = 22'(1) << 3;
  localparam logic [21:0] M_HALTED = 22'(1) << 2, M_ILLEGAL = 22'(1) << 1, M_FAULT = 22'(1);

  typedef struct {
    int          st;
    logic [21:0] sig;
    int          fs;
    int          cnt;
    bit          mr;
    bit          rstn;
    logic [15:0] ir;
    logic [3:0]  flg;
  } step_t;

  step_t       q[$];
  logic [15:0] cur_ir;
  logic [3:0]  cur_flg;
  int          errors = 0;
  int          checks = 0;
  int          step_no = 0;

  function automatic int sat(int i);
    return (i > 7) ? 7 : i;
  endfunction

  function automatic void push(int st, logic [21:0] sg, int cnt, bit mr, int fs = 0, bit rn = 1'b1);
    step_t s;
    s.st = st; s.sig = sg; s.fs = fs; s.cnt = cnt; s.mr = mr; s.rstn = rn;
    s.ir = cur_ir; s.flg = cur_flg;
    q.push_back(s);
  endfunction

  function automatic bit rnd();
    return bit'($urandom_range(0, 1));
  endfunction

  // flg order {C,V,S,Z}
  function automatic bit branch_taken(logic [2:0] cnd, logic [3:0] f);
    case (cnd)
      3'd0: return 1'b1;
      3'd1: return f[0];
      3'd2: return !f[0];
      3'd3: return f[3];
      3'd4: return f[1];
      3'd5: return f[2];
      default: return 1'b0;
    endcase
  endfunction

  // Reset asserted during a cycle in state st: outputs reflect st, then IDLE.
  function automatic void push_rst(int st, logic [21:0] sg, int cnt);
    push(st, sg, cnt, 1'b0, 0, 1'b0);
    push(0, '0, 0, 1'b0, 0, 1'b0);
    push(0, '0, 0, rnd(), 0, 1'b1);
  endfunction

  // Expected cycles of one instruction; wf/wm = wait cycles before mem_ready;
  // abort_wr >= 0 puts reset on the abort_wr-th M_WRITE cycle.
  function automatic void plan(logic [15:0] ir, logic [3:0] f, int wf, int wm, int abort_wr = -1);
    int op;
    cur_ir = ir; cur_flg = f;
    op = int'(ir[15:12]);
    push(1, M_TPC | M_LMAR, 0, rnd());
    for (int i = 0; i <= wf; i++)
      push(2, M_RD | ((i == wf) ? M_LMDR : '0), sat(i), i == wf);
    push(3, M_TMDR | M_LIR | M_LPC | M_PCINC, 0, rnd());
    push(4, (op >= 11 && op <= 14) ? M_ILLEGAL : '0, 0, rnd());
    if (op < 8) begin
      push(5, M_TREG | M_LBUFF, 0, rnd());
      push(6, M_TBUFF | M_LREG, 0, rnd(), op % 8);
    end else if (op == 8) begin
      push(7, M_TLABEL | M_LMAR, 0, rnd());
      for (int i = 0; i <= wm; i++)
        push(8, M_RD | ((i == wm) ? M_LMDR : '0), sat(i), i == wm);
      push(9, M_TMDR | M_LREG, 0, rnd());
    end else if (op == 9) begin
      push(7, M_TLABEL | M_LMAR, 0, rnd());
      push(10, M_TREG | M_LMDR, 0, rnd());
      if (abort_wr >= 0) begin
        for (int i = 0; i < abort_wr; i++) push(11, M_WR, i, 1'b0);
        push_rst(11, M_WR, abort_wr);
      end else begin
        for (int i = 0; i <= wm; i++) push(11, M_WR, sat(i), i == wm);
      end
    end else if (op == 10) begin
      push(12, branch_taken(ir[11:9], f) ? (M_TLABEL | M_LPC) : '0, 0, rnd());
    end else if (op == 15) begin
      push(13, M_HALTED, 0, rnd());
    end
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step %0d: got %0h expected %0h", tag, step_no, obs, exp);
    end
  endtask

  task automatic run_q();
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      IR = s.ir; {C, V, S, Z} = s.flg; mem_ready = s.mr; rst = s.rstn;
      #1;
      chk("state", 32'(state_o), 32'(s.st));
      chk("strobes", 32'({Lmar, Lir, Lbuff, Lpc, Lsp, Lreg, Lmdr, Tpc, Tmar, Tmdr, T1, Tbuff,
                          Tsp, Treg, Tlabel, Tir, rd, wr, pc_inc, halted, illegal, fault}), 32'(s.sig));
      chk("fsel", 32'(fsel), 32'(s.fs));
      chk("count", 32'(count), 32'(s.cnt));
      step_no++;
    end
  endtask

  initial begin
    logic [15:0] rir;
    rst = 1'b0; IR = '0; {C, V, S, Z} = '0; mem_ready = 1'b0;
    cur_ir = '0; cur_flg = '0;
    repeat (2) @(posedge clk);
    push(0, '0, 0, 1'b0, 0, 1'b0);
    push(0, '0, 0, 1'b1, 0, 1'b1);
    run_q();

    plan(16'h2000, 4'h0, 3, 0); run_q();          // ALU, 3 fetch waits, fsel=2
    plan(16'hA200, 4'h0, 0, 0); run_q();          // branch on Z, not taken
    plan(16'hA200, 4'h1, 1, 0); run_q();          // branch on Z, taken
    plan(16'h9005, 4'h0, 0, 2); run_q();          // store, 2 write waits
    plan(16'hC000, 4'h0, 0, 0); run_q();          // illegal opcode
    plan(16'h8123, 4'h0, 2, 4); run_q();          // load
    plan(16'h9005, 4'h0, 0, 0, 2); run_q();       // reset mid M_WRITE

    for (int n = 0; n < 60; n++) begin
      rir = 16'($urandom);
      rir[15:12] = 4'($urandom_range(0, 14));
      plan(rir, 4'($urandom), $urandom_range(0, 6), $urandom_range(0, 6));
      run_q();
    end

`ifdef CTRL_MEM_TIMEOUT_EN
    cur_ir = 16'h3000; cur_flg = 4'h0;
    push(1, M_TPC | M_LMAR, 0, 1'b0);
    for (int i = 0; i < 8; i++) push(2, M_RD, i, 1'b0);
    for (int i = 0; i < 5; i++) push(14, M_FAULT, 0, rnd());
    push_rst(14, M_FAULT, 0);
    run_q();
`else
    plan(16'h3000, 4'h0, 12, 0); run_q();         // long wait, count saturates at 7
`endif

    plan(16'hF400, 4'h0, 0, 0);
    for (int i = 0; i < 99; i++) push(13, M_HALTED, 0, rnd());
    push_rst(13, M_HALTED, 0);
    run_q();
    plan(16'h5000, 4'h0, 1, 0); run_q();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
